dds_wavegen: RTL
================

Name: dds_wavegen

Overview:
Parametrised direct-digital-synthesis waveform generator, successor to the fixed 256x8 sine table.
- Phase accumulator plus quarter-wave sine table, with sine, triangle, sawtooth and square modes.
- Amplitude scaling and phase offset.
- Glitch-free configuration update at period boundary.
- Feeds the DAC / signal-output path of the debugger; one sample per enabled clock.

Parameters:
PHASE_W, 32, phase accumulator width
ADDR_W, 8, waveform index width; full period = 2^ADDR_W points; quarter table Q = 2^(ADDR_W-2)
DATA_W, 8, output sample width, unsigned offset-binary
AMP_W, 8, amplitude fraction bits; amp = 2^AMP_W is unity gain

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
en  in  1  advance accumulator and emit one sample this cycle
phase_clr  in  1  synchronous accumulator clear (acc <= 0)
cfg_load  in  1  capture freq_word/phase_off/wave_sel/amp into shadow
freq_word  in  PHASE_W  phase increment
phase_off  in  PHASE_W  phase offset added after accumulator
wave_sel  in  2  0 sine, 1 triangle, 2 sawtooth, 3 square
amp  in  AMP_W+1  gain, amp/2^AMP_W
cfg_busy  out  1  shadow config pending, not yet active
out_valid  out  1  wave_out carries a new sample
wave_out  out  DATA_W  sample, midscale MID = 2^(DATA_W-1)-1
sync_out  out  1  marks first sample of a period

Behaviour:
- Reset (async): acc=0, active cfg = {freq 0, sine, amp 2^AMP_W, offset 0}, cfg_busy=0, out_valid=0, sync_out=0, wave_out=MID, pipeline valids cleared, first-sample flag set.
- Reset asserted mid-stream: all of the above take effect immediately; samples in flight are discarded.
- Accumulator: at each en edge, sample i uses acc_i, then acc <= acc_i + freq_active, wrapping mod 2^PHASE_W. en low holds acc. phase_clr has priority over the increment.
- Pipeline: 3 register stages.
  - S1: p = acc + phase_off; idx = p[PHASE_W-1 -: ADDR_W]; mode and amp staged.
  - S2: table read; sign and magnitude resolved.
  - S3: scale and offset.
  - Timing: en at edge k gives wave_out/out_valid updated at edge k+2. out_valid is en delayed by 3 stages.
  - wave_out holds its last value when out_valid=0.
- Sine, with quadrant qd = idx[ADDR_W-1:ADDR_W-2] and l = low ADDR_W-2 bits:
  - Table: mag[i] = round(MID*sin(pi*i/(2Q))), i = 0..Q (Q+1 entries).
  - s = +mag[l], +mag[Q-l], -mag[l], -mag[Q-l] for qd = 0..3.
- Triangle: t = p[PHASE_W-1 -: DATA_W+1]; u = t[DATA_W] ? ~t[DATA_W-1:0] : t[DATA_W-1:0]; s = u - 2^(DATA_W-1).
- Sawtooth: s = p[PHASE_W-1 -: DATA_W] - 2^(DATA_W-1).
- Square: s = p[PHASE_W-1] ? -MID : +MID.
- Triangle and sawtooth clamp s = -2^(DATA_W-1) to -MID.
- Scaling: wave_out = MID + ((s*amp) >>> AMP_W), arithmetic shift (floor). Signed intermediate width DATA_W+AMP_W+2. No overflow for amp <= 2^AMP_W. amp > 2^AMP_W saturates the result to 0 .. 2*MID.
- Config update:
  - cfg_load captures inputs into shadow and sets cfg_busy.
  - If en=0, or an increment carries out of acc on that edge, shadow goes to active at that edge and cfg_busy clears.
  - Otherwise the pending shadow is applied at the first wrapping edge.
  - A repeated cfg_load while busy overwrites the shadow.
  - phase_clr also applies a pending shadow.
- sync_out: accompanies sample i when i is the first sample after reset/phase_clr, or when acc_i was produced by a wrapping increment.

Optional Feature:
DDS_PHASE_DITHER_EN
- Defined: 16-bit Galois LFSR (taps 0xB400, reset seed 0xACE1) advances on en. Its top bits are added to the truncated phase bits p[PHASE_W-ADDR_W-1:0] before index extraction.
- Undefined: plain truncation, fully deterministic. All test-plan values assume it is undefined.

Decomposition:
- Package dds_pkg: wave_sel constants WAVE_SINE/WAVE_TRI/WAVE_SAW/WAVE_SQR, function mid_val(DATA_W), function qsin_mag(i, Q, DATA_W) used to initialise the table, LFSR seed/taps constants.
- Sub-module dds_qsin_rom: synchronous quarter-wave ROM, Q+1 entries, 1-cycle read latency, occupies S2.

Test Plan:
- Defaults, sine, freq_word=2^24, amp=256, en held -> samples 0,1,2 = 0x7f,0x82,0x85; sample 64 = 0xfe; sample 128 = 0x7f; sample 192 = 0x00; sync_out on samples 0 and 256.
- Same with amp=128 -> sample 64 = 0xbe, sample 192 = 0x3f, sample 0 = 0x7f.
- Mode checks at freq 2^24:
  - square: sample 0 = 0xfe, sample 128 = 0x00.
  - sawtooth: sample 0 = 0x00, sample 255 = 0xfe.
  - triangle: sample 0 = 0x00, sample 128 = 0xfe.
- cfg_load freq=2^25 at sample 100 with en high -> cfg_busy high until the wrap edge; step stays 1 through sample 255; step is 2 from the next period.
- Stream, then rst pulse mid-period -> same cycle: out_valid=0, wave_out=0x7f, cfg_busy=0. After release, sample 0 = 0x7f with sync_out.
- en low for 5 cycles mid-stream -> out_valid drops 3 stages later; wave_out holds; on resume, samples continue from the held acc with no skipped index.

Source files
------------

// File: rtl/dds_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dds_pkg
//  Description : Shared constants and helpers for the DDS waveform generator:
//                waveform select codes, LFSR constants, midscale and
//                quarter-wave sine magnitude functions.
//  Revision    : 1.0 - initial release
// ============================================================================
package dds_pkg;

    localparam logic [1:0] WAVE_SINE = 2'd0;
    localparam logic [1:0] WAVE_TRI  = 2'd1;
    localparam logic [1:0] WAVE_SAW  = 2'd2;
    localparam logic [1:0] WAVE_SQR  = 2'd3;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // pi in Q28 fixed point; the sine table is built without real arithmetic
    localparam int     c_FX_SH = 28;
    localparam longint c_PI_FX = 64'sd843314857;

    function automatic int mid_val(input int data_w);
        return (1 << (data_w - 1)) - 1;
    endfunction

    // round(MID * sin(pi*i/(2q))) via a Q28 Taylor series to x^15
    function automatic int qsin_mag(input int i, input int q, input int data_w);
        longint x;
        longint x2;
        longint term;
        longint sum;
        x    = (c_PI_FX * longint'(i)) / longint'(2 * q);
        x2   = (x * x) >>> c_FX_SH;
        term = x;
        sum  = x;
        for (int k = 1; k <= 7; k++) begin
            term = -((term * x2) >>> c_FX_SH) / longint'((2 * k) * (2 * k + 1));
            sum  = sum + term;
        end
        return int'((sum * longint'(mid_val(data_w)) + (longint'(1) <<< (c_FX_SH - 1))) >>> c_FX_SH);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dds_qsin_rom.sv
`default_nettype none
// ============================================================================
//  Module      : dds_qsin_rom
//  Description : Synchronous quarter-wave sine magnitude ROM, Q+1 entries
//                (index 0..Q inclusive), one clock of read latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module dds_qsin_rom
    import dds_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic [ADDR_W-2:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    localparam int c_Q = 2 ** (ADDR_W - 2);

    logic [DATA_W-1:0] w_table [0:c_Q];

    for (genvar gi = 0; gi <= c_Q; gi++) begin : g_table
        assign w_table[gi] = DATA_W'(qsin_mag(gi, c_Q, DATA_W));
    end

    // registered table read
    always_ff @(posedge clk) begin
        rd_data <= w_table[rd_addr];
    end

endmodule
`default_nettype wire

// File: rtl/dds_wavegen.sv
`default_nettype none
// ============================================================================
//  Module      : dds_wavegen
//  Description : DDS waveform generator. Phase accumulator, 3-stage sample
//                pipeline (phase/index, table read, scale/offset), sine /
//                triangle / sawtooth / square, amplitude scaling, phase
//                offset and period-aligned configuration update.
//                Optional macro DDS_PHASE_DITHER_EN adds LFSR phase dither.
//  Revision    : 1.0 - initial release
// ============================================================================
module dds_wavegen
    import dds_pkg::*;
#(
    parameter int PHASE_W = 32,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int AMP_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               phase_clr,
    input  logic               cfg_load,
    input  logic [PHASE_W-1:0] freq_word,
    input  logic [PHASE_W-1:0] phase_off,
    input  logic [1:0]         wave_sel,
    input  logic [AMP_W:0]     amp,
    output logic               cfg_busy,
    output logic               out_valid,
    output logic [DATA_W-1:0]  wave_out,
    output logic               sync_out
);

    localparam int c_MID = mid_val(DATA_W);
    localparam int c_Q   = 2 ** (ADDR_W - 2);
    localparam int c_PW  = DATA_W + AMP_W + 2;

    localparam logic signed [DATA_W:0] c_MID_S   = (DATA_W + 1)'(c_MID);
    localparam logic signed [DATA_W:0] c_NMID_S  = -c_MID_S;
    localparam logic signed [DATA_W:0] c_HALF_S  = (DATA_W + 1)'(2 ** (DATA_W - 1));
    localparam logic signed [DATA_W:0] c_NHALF_S = -c_HALF_S;
    localparam logic signed [c_PW-1:0] c_MID_W   = c_PW'(c_MID);
    localparam logic signed [c_PW-1:0] c_TOP_W   = c_PW'(2 * c_MID);
    localparam logic [AMP_W:0]         c_UNITY   = (AMP_W + 1)'(2 ** AMP_W);

    // accumulator and configuration state
    logic [PHASE_W-1:0] r_acc;
    logic               r_sync;
    logic [PHASE_W-1:0] r_freq, r_off, r_sh_freq, r_sh_off;
    logic [1:0]         r_mode, r_sh_mode;
    logic [AMP_W:0]     r_amp, r_sh_amp;
    logic               r_busy;

    logic [PHASE_W:0]   w_sum;
    logic               w_carry;
    logic               w_wrap;
    logic [PHASE_W-1:0] w_psum;

    assign w_sum    = {1'b0, r_acc} + {1'b0, r_freq};
    assign w_carry  = w_sum[PHASE_W];
    assign w_wrap   = en & ~phase_clr & w_carry;
    assign cfg_busy = r_busy;

`ifdef DDS_PHASE_DITHER_EN
    // dither sits directly below the table index (assumes PHASE_W-ADDR_W >= 16)
    logic [15:0] r_lfsr;

    // Galois LFSR stepping once per emitted sample
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lfsr <= LFSR_SEED;
        end else if (en) begin
            r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? LFSR_TAPS : 16'h0000);
        end
    end

    assign w_psum = r_acc + r_off + (PHASE_W'(r_lfsr) << (PHASE_W - ADDR_W - 16));
`else
    assign w_psum = r_acc + r_off;
`endif

    // phase accumulator and first-sample-of-period flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc  <= '0;
            r_sync <= 1'b1;
        end else if (phase_clr) begin
            r_acc  <= '0;
            r_sync <= 1'b1;
        end else if (en) begin
            r_acc  <= w_sum[PHASE_W-1:0];
            r_sync <= w_carry;
        end
    end

    // shadow capture and period-aligned promotion to the active configuration
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_freq    <= '0;
            r_off     <= '0;
            r_mode    <= WAVE_SINE;
            r_amp     <= c_UNITY;
            r_sh_freq <= '0;
            r_sh_off  <= '0;
            r_sh_mode <= WAVE_SINE;
            r_sh_amp  <= c_UNITY;
            r_busy    <= 1'b0;
        end else if (cfg_load) begin
            r_sh_freq <= freq_word;
            r_sh_off  <= phase_off;
            r_sh_mode <= wave_sel;
            r_sh_amp  <= amp;
            if (!en || w_wrap || phase_clr) begin
                r_freq <= freq_word;
                r_off  <= phase_off;
                r_mode <= wave_sel;
                r_amp  <= amp;
                r_busy <= 1'b0;
            end else begin
                r_busy <= 1'b1;
            end
        end else if (r_busy && (w_wrap || phase_clr)) begin
            r_freq <= r_sh_freq;
            r_off  <= r_sh_off;
            r_mode <= r_sh_mode;
            r_amp  <= r_sh_amp;
            r_busy <= 1'b0;
        end
    end

    // ---------------- S1: phase, index, staged mode/amp ----------------
    logic               r_v1, r_s1_sync;
    logic [ADDR_W-1:0]  r_s1_idx;
    logic [DATA_W:0]    r_s1_t;
    logic [1:0]         r_s1_mode;
    logic [AMP_W:0]     r_s1_amp;

    // ---------------- S2: table read, sign, non-sine sample ----------------
    logic               r_v2, r_s2_sync, r_s2_neg, r_s2_sine;
    logic signed [DATA_W:0] r_s2_alt;
    logic [AMP_W:0]     r_s2_amp;
    logic [DATA_W-1:0]  w_mag;

    logic [1:0]          w_qd;
    logic [ADDR_W-3:0]   w_l;
    logic [ADDR_W-2:0]   w_rom_addr;
    logic [DATA_W-1:0]   w_u;
    logic signed [DATA_W:0] w_alt_raw, w_alt;

    assign w_qd       = r_s1_idx[ADDR_W-1:ADDR_W-2];
    assign w_l        = r_s1_idx[ADDR_W-3:0];
    // odd quadrants read the table backwards, from Q down to 1
    assign w_rom_addr = w_qd[0] ? ((ADDR_W - 1)'(c_Q) - {1'b0, w_l}) : {1'b0, w_l};
    assign w_u        = r_s1_t[DATA_W] ? ~r_s1_t[DATA_W-1:0] : r_s1_t[DATA_W-1:0];

    // triangle/sawtooth/square sample, clamped to be symmetric about midscale
    always_comb begin
        w_alt_raw = r_s1_t[DATA_W] ? c_NMID_S : c_MID_S;
        case (r_s1_mode)
            WAVE_TRI: w_alt_raw = $signed({1'b0, w_u}) - c_HALF_S;
            WAVE_SAW: w_alt_raw = $signed({1'b0, r_s1_t[DATA_W:1]}) - c_HALF_S;
            default:  ;
        endcase
        w_alt = (w_alt_raw == c_NHALF_S) ? c_NMID_S : w_alt_raw;
    end

    dds_qsin_rom #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_rom (
        .clk     (clk),
        .rd_addr (w_rom_addr),
        .rd_data (w_mag)
    );

    // ---------------- S3: scale, offset, saturate ----------------
    logic signed [DATA_W:0]   w_mag_s, w_s;
    logic signed [c_PW-1:0]   w_prod, w_res;
    logic [DATA_W-1:0]        w_sample;

    assign w_mag_s = $signed({1'b0, w_mag});
    assign w_prod  = c_PW'(w_s) * $signed(c_PW'(r_s2_amp));
    assign w_res   = (w_prod >>> AMP_W) + c_MID_W;

    // signed sample selection and output range clamp for gains above unity
    always_comb begin
        w_s = r_s2_alt;
        if (r_s2_sine) begin
            w_s = r_s2_neg ? -w_mag_s : w_mag_s;
        end
        if (w_res[c_PW-1]) begin
            w_sample = '0;
        end else if (w_res > c_TOP_W) begin
            w_sample = DATA_W'(2 * c_MID);
        end else begin
            w_sample = DATA_W'(w_res);
        end
    end

    // three-stage sample pipeline with valid/sync tracking
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v1      <= 1'b0;
            r_s1_sync <= 1'b0;
            r_s1_idx  <= '0;
            r_s1_t    <= '0;
            r_s1_mode <= WAVE_SINE;
            r_s1_amp  <= '0;
            r_v2      <= 1'b0;
            r_s2_sync <= 1'b0;
            r_s2_neg  <= 1'b0;
            r_s2_sine <= 1'b0;
            r_s2_alt  <= '0;
            r_s2_amp  <= '0;
            out_valid <= 1'b0;
            sync_out  <= 1'b0;
            wave_out  <= DATA_W'(c_MID);
        end else begin
            r_v1      <= en;
            r_s1_sync <= r_sync;
            r_s1_idx  <= ADDR_W'(w_psum >> (PHASE_W - ADDR_W));
            r_s1_t    <= (DATA_W + 1)'(w_psum >> (PHASE_W - DATA_W - 1));
            r_s1_mode <= r_mode;
            r_s1_amp  <= r_amp;
            r_v2      <= r_v1;
            r_s2_sync <= r_s1_sync;
            r_s2_neg  <= w_qd[1];
            r_s2_sine <= (r_s1_mode == WAVE_SINE);
            r_s2_alt  <= w_alt;
            r_s2_amp  <= r_s1_amp;
            out_valid <= r_v2;
            sync_out  <= r_v2 & r_s2_sync;
            if (r_v2) begin
                wave_out <= w_sample;
            end
        end
    end

endmodule
`default_nettype wire
